// File: rtl/rrf_pkg.sv
// Shared sizing for the retirement register file: architectural and physical
// register counts, index widths and the index types derived from them.
package rrf_pkg;
    localparam int ARF_DEPTH = 32;
    localparam int PRF_DEPTH = 64;
    localparam int ARF_IDX   = $clog2(ARF_DEPTH);
    localparam int PRF_IDX   = $clog2(PRF_DEPTH);
    localparam int MAP_W     = ARF_DEPTH * PRF_IDX;
    localparam int CNT_W     = 64;

    typedef logic [ARF_IDX-1:0] arch_t;
    typedef logic [PRF_IDX-1:0] phy_t;
    typedef phy_t [ARF_DEPTH-1:0] map_t;
endpackage

// File: rtl/rrf_perf_counter.sv
// Free-running event counter, wraps modulo 2^WIDTH; reusable for any perf event.
module rrf_perf_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/rrf.sv
// Retirement register file: committed arch->phys map updated by in-order ROB
// retirement, returning each displaced phys reg to the free list one cycle later.
module rrf
    import rrf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               from_rob_valid,
    input  logic [PRF_IDX-1:0] from_rob_rd_phy,
    input  logic [ARF_IDX-1:0] from_rob_rd_arch,
    output logic               to_fl_valid,
    output logic [PRF_IDX-1:0] to_fl_free_idx,
    input  logic               flush,
    output logic [MAP_W-1:0]   committed_map,
    output logic [CNT_W-1:0]   retire_cnt
);
    map_t map_q, map_d;
    logic fl_valid_q, fl_valid_d;
    phy_t fl_idx_q, fl_idx_d;
    logic commit;
    logic alloc_clash;
    logic unused_flush;

    // The RAT copies committed_map on flush; this block itself does nothing.
    assign unused_flush = flush;

    assign commit = from_rob_valid && (from_rob_rd_arch != '0);

    always_comb begin
        map_d      = map_q;
        fl_valid_d = 1'b0;
        fl_idx_d   = fl_idx_q;
        if (commit) begin
            map_d[from_rob_rd_arch] = from_rob_rd_phy;
            fl_valid_d              = 1'b1;
            fl_idx_d                = map_q[from_rob_rd_arch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARF_DEPTH; i++) map_q[i] <= PRF_IDX'(i);
            fl_valid_q <= 1'b0;
            fl_idx_q   <= '0;
        end else begin
            map_q      <= map_d;
            fl_valid_q <= fl_valid_d;
            fl_idx_q   <= fl_idx_d;
        end
    end

    rrf_perf_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (from_rob_valid),
        .cnt_o (retire_cnt)
    );

    assign to_fl_valid    = fl_valid_q;
    assign to_fl_free_idx = fl_idx_q;
    assign committed_map  = map_q;

    always_comb begin
        alloc_clash = 1'b0;
        for (int i = 0; i < ARF_DEPTH; i++)
            if (map_q[i] == from_rob_rd_phy) alloc_clash = 1'b1;
    end

    a_phy_known: assert property (@(posedge clk) disable iff (rst)
        from_rob_valid |-> !$isunknown(from_rob_rd_phy));

    a_no_double_alloc: assert property (@(posedge clk) disable iff (rst)
        commit |-> !alloc_clash);
endmodule

// File: tb/tb_rrf.sv
// Randomized scoreboard bench for rrf: expected frees queued at issue, popped by a monitor.
module tb_rrf;
    localparam int ARF = 32;
    localparam int PRF = 64;
    localparam int PI  = 6;
    localparam int AI  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          from_rob_valid;
    logic [PI-1:0] from_rob_rd_phy;
    logic [AI-1:0] from_rob_rd_arch;
    logic          to_fl_valid;
    logic [PI-1:0] to_fl_free_idx;
    logic          flush;
    logic [ARF*PI-1:0] committed_map;
    logic [63:0]   retire_cnt;

    int vectors = 0;
    int miscompares = 0;

    int      ref_map [ARF];
    longint  ref_cnt;
    int      exp_q[$];
    int      pool[$];
    bit      mon_en = 1'b0;

    rrf dut (
        .clk              (clk),
        .rst              (rst),
        .from_rob_valid   (from_rob_valid),
        .from_rob_rd_phy  (from_rob_rd_phy),
        .from_rob_rd_arch (from_rob_rd_arch),
        .to_fl_valid      (to_fl_valid),
        .to_fl_free_idx   (to_fl_free_idx),
        .flush            (flush),
        .committed_map    (committed_map),
        .retire_cnt       (retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    function automatic int dmap(int i);
        return int'(committed_map[i*PI +: PI]);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: act=%0d req=%0d", name, act, exp);
        end
    endtask

    // Monitor: every free the DUT presents must be the oldest outstanding one.
    always @(negedge clk) begin
        if (mon_en && !rst && to_fl_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL free_stream: act=%0d req=none", to_fl_free_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(to_fl_free_idx) != e) begin
                    miscompares++;
                    $display("FAIL free_stream: act=%0d req=%0d", to_fl_free_idx, e);
                end
            end
            pool.push_back(int'(to_fl_free_idx));
        end
    end

    // One cycle of stimulus; returns 1 time unit after the edge that samples it.
    task automatic drive(bit v, int a, int p, bit f);
        from_rob_valid   = v;
        from_rob_rd_arch = AI'(a);
        from_rob_rd_phy  = PI'(p);
        flush            = f;
        if (v) begin
            ref_cnt++;
            if (a != 0) begin
                exp_q.push_back(ref_map[a]);
                ref_map[a] = p;
                foreach (pool[k]) if (pool[k] == p) begin pool.delete(k); break; end
            end
        end
        @(posedge clk);
        #1;
        from_rob_valid = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic check_map(string name);
        int bad;
        bad = 0;
        for (int i = 0; i < ARF; i++) if (dmap(i) != ref_map[i]) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        from_rob_valid = 1'b0; from_rob_rd_phy = '0; from_rob_rd_arch = '0; flush = 1'b0;
        for (int i = 0; i < ARF; i++) ref_map[i] = i;
        ref_cnt = 0;
        for (int p = ARF; p < PRF; p++) pool.push_back(p);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_map("reset_map_identity");
        chk("reset_fl_valid", to_fl_valid, 0);
        chk("reset_free_idx", to_fl_free_idx, 0);
        chk("reset_retire_cnt", retire_cnt, 0);
        mon_en = 1'b1;

        // single commit
        drive(1, 5, 40, 0);
        chk("c1_fl_valid", to_fl_valid, 1);
        chk("c1_free_idx", to_fl_free_idx, 5);
        chk("c1_map5", dmap(5), 40);
        chk("c1_cnt", retire_cnt, 1);
        drive(0, 0, 0, 0);
        chk("idle_fl_valid", to_fl_valid, 0);

        // back-to-back to the same arch reg
        drive(1, 7, 33, 0);
        chk("b2b_first_free", to_fl_free_idx, 7);
        drive(1, 7, 34, 0);
        chk("b2b_second_valid", to_fl_valid, 1);
        chk("b2b_second_free", to_fl_free_idx, 33);
        chk("b2b_map7", dmap(7), 34);

        // x0 commit: counted, not mapped, not freed
        drive(1, 0, 12, 0);
        chk("x0_fl_valid", to_fl_valid, 0);
        chk("x0_map0", dmap(0), 0);
        chk("x0_cnt", retire_cnt, 4);

        // commit together with flush still applies
        from_rob_valid = 1'b1; from_rob_rd_arch = AI'(3); from_rob_rd_phy = PI'(50);
        #1;
        chk("precommit_map3", dmap(3), 3);
        drive(1, 3, 50, 1);
        chk("flush_map3", dmap(3), 50);
        chk("flush_fl_valid", to_fl_valid, 1);
        chk("flush_free_idx", to_fl_free_idx, 3);
        check_map("directed_map");

        // randomized retirement stream
        for (int n = 0; n < 10000; n++) begin
            int r, a, p, idx;
            r = int'($urandom_range(99));
            a = (($urandom_range(7)) == 0) ? 0 : int'($urandom_range(ARF-1, 1));
            idx = int'($urandom_range(pool.size()-1));
            p = pool[idx];
            drive(r < 75, a, p, ($urandom_range(15)) == 0);
            if ((n % 1000) == 999) begin
                check_map("rand_map");
                chk("rand_cnt", retire_cnt, ref_cnt);
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rand_pending_frees", exp_q.size(), 0);
        check_map("rand_final_map");
        chk("rand_final_cnt", retire_cnt, ref_cnt);
        begin
            int bad;
            int seen [PRF];
            bad = 0;
            for (int p = 0; p < PRF; p++) seen[p] = 0;
            for (int i = 0; i < ARF; i++) seen[dmap(i)]++;
            foreach (pool[k]) seen[pool[k]]++;
            for (int p = 0; p < PRF; p++) if (seen[p] != 1) bad++;
            chk("phys_reg_conservation", bad, 0);
        end

        // reset while a commit is presented: no free, map back to identity
        mon_en = 1'b0;
        rst = 1'b1;
        from_rob_valid = 1'b1; from_rob_rd_arch = AI'(9); from_rob_rd_phy = PI'(pool[0]);
        @(posedge clk);
        #1;
        from_rob_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < ARF; i++) ref_map[i] = i;
        chk("midrst_fl_valid", to_fl_valid, 0);
        check_map("midrst_map_identity");
        chk("midrst_cnt", retire_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
